// File: rtl/config_loader_if.sv
// Load-side bundle between the host front end and the config loader:
// word handshake plus the completion/readback report.
interface config_loader_if #(
    parameter int ClockConfigWidth = 6,
    parameter int ScaleWidth       = 6
);
    localparam int ShiftRegSize = ClockConfigWidth + 2 * ScaleWidth;

    logic                        loadValid;
    logic                        loadReady;
    logic [ClockConfigWidth-1:0] clockConfigIn;
    logic [ScaleWidth-1:0]       adcScaleIn;
    logic [ScaleWidth-1:0]       dacScaleIn;
    logic                        done;
    logic [ShiftRegSize-1:0]     readbackData;
    logic                        verifyError;

    modport master (
        output loadValid,
        output clockConfigIn,
        output adcScaleIn,
        output dacScaleIn,
        input  loadReady,
        input  done,
        input  readbackData,
        input  verifyError
    );

    modport slave (
        input  loadValid,
        input  clockConfigIn,
        input  adcScaleIn,
        input  dacScaleIn,
        output loadReady,
        output done,
        output readbackData,
        output verifyError
    );
endinterface

// File: rtl/config_loader.sv
// Shifts a config word MSB-first into the store chain while capturing
// the chain's previous contents and checking them against the last write.
module config_loader #(
    parameter int ClockConfigWidth = 6,
    parameter int ScaleWidth       = 6
) (
    input  logic            clk,
    input  logic            resetN,
    config_loader_if.slave  load,
    output logic            serialEn,
    output logic            serialIn,
    input  logic            serialOut
);
    localparam int N  = ClockConfigWidth + 2 * ScaleWidth;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  tx;
    logic [N-1:0]  rx;
    logic [N-1:0]  word;
    logic [N-1:0]  shadow;
    logic [N-1:0]  word_in;
    logic [N-1:0]  rx_next;
    logic          ready_q;
    logic          en_q;
    logic          done_q;
    logic [N-1:0]  rb_q;
    logic          err_q;

    assign word_in = {load.dacScaleIn, load.adcScaleIn,
                      load.clockConfigIn};
    assign rx_next = {rx[N-2:0], serialOut};

    // tx is empty outside SHIFT, so its MSB doubles as the idle-low data
    assign serialIn = tx[N-1];
    assign serialEn = en_q;

    assign load.loadReady    = ready_q;
    assign load.done         = done_q;
    assign load.readbackData = rb_q;
    assign load.verifyError  = err_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state   <= IDLE;
            cnt     <= '0;
            tx      <= '0;
            rx      <= '0;
            word    <= '0;
            shadow  <= '0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            rb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load.loadValid) begin
                        tx      <= word_in;
                        word    <= word_in;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        en_q    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    tx <= {tx[N-2:0], 1'b0};
                    rx <= rx_next;
                    if (cnt == LAST) begin
                        en_q   <= 1'b0;
                        done_q <= 1'b1;
                        rb_q   <= rx_next;
                        err_q  <= (rx_next != shadow);
                        shadow <= word;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: drives loads into an 18-bit store model and
// scoreboards readback, verify flag, serial stream and done timing.
module tb_config_loader;
    localparam int N = 18;

    typedef struct {
        logic [N-1:0] word;
        logic [N-1:0] rb;
        logic         ve;
    } exp_t;

    typedef struct {
        logic         poke;
        logic [N-1:0] poke_val;
        logic [5:0]   dac;
        logic [5:0]   adc;
        logic [5:0]   cfg;
        logic [N-1:0] rb;
        logic         ve;
    } vec_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic serialEn;
    logic serialIn;
    logic serialOut;

    logic [N-1:0] store;
    logic         poke = 1'b0;
    logic [N-1:0] poke_val = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_total = 0;
    int en_cnt = 0;
    logic [N-1:0] bits = '0;

    exp_t sb_q[$];
    int   acc_q[$];
    int   acc_log[$];
    vec_t vecs[4];

    config_loader_if #(.ClockConfigWidth(6), .ScaleWidth(6)) bus ();

    config_loader #(.ClockConfigWidth(6), .ScaleWidth(6)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .load      (bus.slave),
        .serialEn  (serialEn),
        .serialIn  (serialIn),
        .serialOut (serialOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // configuration store: shift chain sharing the loader's reset
    always @(posedge clk) begin
        if (!resetN)
            store <= '0;
        else if (poke)
            store <= poke_val;
        else if (serialEn)
            store <= {store[N-2:0], serialIn};
    end
    assign serialOut = store[N-1];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!resetN) begin
            acc_q.delete();
            en_cnt = 0;
            bits = '0;
        end else begin
            if (bus.loadValid && bus.loadReady) begin
                acc_q.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
                acc_total++;
            end
            if (serialEn) begin
                bits = {bits[N-2:0], serialIn};
                en_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                if (sb_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    int a;
                    e = sb_q.pop_front();
                    a = acc_q.pop_front();
                    chk("readback", 32'(bus.readbackData), 32'(e.rb));
                    chk("verify_err", 32'(bus.verifyError), 32'(e.ve));
                    chk("store", 32'(store), 32'(e.word));
                    chk("serial_bits", 32'(bits), 32'(e.word));
                    chk("en_cycles", en_cnt, N);
                    chk("done_cycle", cyc, a + N);
                end
                en_cnt = 0;
                bits = '0;
            end
        end
    end

    task automatic wait_dones(input int n);
        int target;
        int k;
        target = done_cnt + n;
        k = 0;
        while (done_cnt < target && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt < target)
            chk("done_timeout", done_cnt, target);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.loadReady && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!bus.loadReady)
            chk("ready_timeout", 0, 1);
    endtask

    task automatic drive(input logic [5:0] dac, input logic [5:0] adc,
                         input logic [5:0] cfg);
        wait_ready();
        bus.dacScaleIn    = dac;
        bus.adcScaleIn    = adc;
        bus.clockConfigIn = cfg;
        bus.loadValid     = 1'b1;
        @(posedge clk);
        #1;
        bus.loadValid = 1'b0;
    endtask

    task automatic push_exp(input logic [N-1:0] w, input logic [N-1:0] rb,
                            input logic ve);
        exp_t e;
        e.word = w;
        e.rb   = rb;
        e.ve   = ve;
        sb_q.push_back(e);
    endtask

    task automatic do_poke(input logic [N-1:0] v);
        poke_val = v;
        poke = 1'b1;
        @(posedge clk);
        #1;
        poke = 1'b0;
    endtask

    initial begin
        int a0;
        int d0;

        vecs[0] = '{1'b0, 18'h0, 6'h2A, 6'h15, 6'h3F, 18'h00000, 1'b0};
        vecs[1] = '{1'b0, 18'h0, 6'h00, 6'h00, 6'h01, 18'h2A57F, 1'b0};
        vecs[2] = '{1'b1, 18'h12345, 6'h3F, 6'h3F, 6'h3F,
                    18'h12345, 1'b1};
        vecs[3] = '{1'b0, 18'h0, 6'h0F, 6'h03, 6'h30, 18'h3FFFF, 1'b0};

        bus.loadValid = 1'b0;
        bus.dacScaleIn = '0;
        bus.adcScaleIn = '0;
        bus.clockConfigIn = '0;

        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.loadReady), 1);
        chk("rst_en", 32'(serialEn), 0);
        chk("rst_sin", 32'(serialIn), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rb", 32'(bus.readbackData), 0);
        chk("rst_ve", 32'(bus.verifyError), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].poke)
                do_poke(vecs[i].poke_val);
            push_exp({vecs[i].dac, vecs[i].adc, vecs[i].cfg},
                     vecs[i].rb, vecs[i].ve);
            drive(vecs[i].dac, vecs[i].adc, vecs[i].cfg);
            wait_dones(1);
            chk("rb_hold", 32'(bus.readbackData), 32'(vecs[i].rb));
        end

        // loadValid held high: three back-to-back accepts
        push_exp(18'h15555, 18'h0F0F0, 1'b0);
        push_exp(18'h15555, 18'h15555, 1'b0);
        push_exp(18'h15555, 18'h15555, 1'b0);
        a0 = acc_log.size();
        bus.dacScaleIn = 6'h15;
        bus.adcScaleIn = 6'h15;
        bus.clockConfigIn = 6'h15;
        bus.loadValid = 1'b1;
        wait_dones(3);
        bus.loadValid = 1'b0;
        chk("hold_accepts", acc_log.size() - a0, 3);
        if (acc_log.size() >= a0 + 3) begin
            chk("spacing1", acc_log[a0+1] - acc_log[a0], N + 2);
            chk("spacing2", acc_log[a0+2] - acc_log[a0+1], N + 2);
        end

        // loadValid pulsed mid-shift is ignored
        a0 = acc_total;
        push_exp(18'h00FC0, 18'h15555, 1'b0);
        drive(6'h00, 6'h3F, 6'h00);
        repeat (5) @(posedge clk);
        #1;
        bus.dacScaleIn = 6'h3F;
        bus.clockConfigIn = 6'h3F;
        bus.loadValid = 1'b1;
        @(posedge clk);
        #1;
        bus.loadValid = 1'b0;
        wait_dones(1);
        repeat (4) @(posedge clk);
        #1;
        chk("pulse_accepts", acc_total - a0, 1);
        chk("pulse_idle_en", 32'(serialEn), 0);

        // reset while bit 7 is on the wire
        d0 = done_cnt;
        drive(6'h2A, 6'h2A, 6'h2A);
        repeat (7) @(posedge clk);
        #1;
        chk("abort_mid_en", 32'(serialEn), 1);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        chk("abort_en", 32'(serialEn), 0);
        chk("abort_ready", 32'(bus.loadReady), 1);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);

        push_exp({6'h01, 6'h02, 6'h03}, 18'h0, 1'b0);
        drive(6'h01, 6'h02, 6'h03);
        wait_dones(1);

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/config_loader.md
# config_loader

Parallel-to-serial loader that drives the configuration shift-register chain. It accepts a complete configuration word (clock config, ADC scale, DAC scale) over a valid/ready handshake and shifts it MSB-first into the store's serial input. It captures the store's previous contents from the store's serial output during the same pass, and flags whether the readback matches the last word written. It sits between the host/config front end and the configuration store, on the same clock.

## Interface
- ClockConfigWidth, 6, width of clock-config field
- ScaleWidth, 6, width of each scale field
- ShiftRegSize (localparam), ClockConfigWidth + 2*ScaleWidth = 18, chain length N
- clk  input  1  system clock
- resetN  input  1  synchronous, active-low reset
- loadValid  input  1  new config word offered
- loadReady  output  1  loader idle, can accept
- clockConfigIn  input  ClockConfigWidth  clock-config field of new word
- adcScaleIn  input  ScaleWidth  ADC scale field
- dacScaleIn  input  ScaleWidth  DAC scale field
- serialEn  output  1  store shifts one bit on each clk edge where high
- serialIn  output  1  bit presented to store
- serialOut  input  1  MSB of store chain
- done  output  1  one-cycle pulse, load finished
- readbackData  output  N  store contents before this load
- verifyError  output  1  readbackData != last word written; valid with done, held until next done

## Operation
- Word packing: word = {dacScaleIn, adcScaleIn, clockConfigIn}, N bits. After a full pass the store holds exactly this word.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - loadReady=1, serialEn=0, serialIn=0.
  - On loadValid&&loadReady, latch the word into a transmit register, clear bit counter, go to SHIFT.
- SHIFT:
  - loadReady=0, serialEn=1, serialIn=tx[N-1]; on each edge tx shifts left by one.
  - On each edge, sample serialOut into the LSB of the readback shift register (shift left).
  - Bit counter 0..N-1; at count N-1 go to DONE.
  - Inputs other than serialOut are ignored.
- DONE (one cycle):
  - done=1, loadReady=0, serialEn=0.
  - readbackData and verifyError are updated on entry to DONE.
  - verifyError = (captured readback != shadow), where shadow is the last word written.
  - Shadow is then updated to the current word; go to IDLE.
- Shadow resets to 0, matching the store's reset value. After a common reset, the first load's readback is 0 with verifyError=0.
- Counter width is $clog2(N); it never wraps past N-1.
- No back-to-back acceptance: loadValid held high through a load is accepted again only in the IDLE cycle after DONE.

## Timing
- Reset (resetN low at an edge) → state IDLE.
  - Outputs after reset: loadReady=1, serialEn=0, serialIn=0, done=0, readbackData=0, verifyError=0.
  - Internal state after reset: shadow=0, counter=0.
- Reset mid-SHIFT aborts immediately. Next cycle serialEn=0; the partial shift is not reported (done never pulses). Shadow is also cleared, so reset the store together with the loader.
- Accept at edge T (loadValid&&loadReady sampled high):
  - SHIFT occupies cycles T+1 … T+N; serialEn high exactly N cycles.
  - The bit presented in cycle T+1+k is word[N-1-k].
  - serialOut sampled in cycle T+1+k equals old[N-1-k].
- done is high in cycle T+N+1 only.
- loadReady returns high in cycle T+N+2; minimum accept-to-accept spacing is N+2 cycles.
- readbackData and verifyError change only on entry to DONE, and are stable otherwise.

## Test plan
- Reset: hold resetN=0 for 2 cycles → loadReady=1, serialEn=0, done=0, readbackData=0, verifyError=0.
- Single load, loader chained to a store model of N=18 bits, store reset to 0:
  - Stimulus: load dac=0x2A, adc=0x15, clk=0x3F.
  - serialEn high exactly 18 cycles; bit sequence 101010 010101 111111.
  - Store holds 0x2A57F (18-bit); done pulses at T+19.
  - readbackData=0, verifyError=0.
- Second load: load 0x00001 → readbackData=0x2A57F, verifyError=0, store=0x00001.
- Corrupt the store (force store to 0x12345 between loads), then load 0x3FFFF → readbackData=0x12345, verifyError=1.
- Handshake:
  - loadValid held high continuously → accepts spaced exactly 20 cycles apart.
  - loadValid pulsed while in SHIFT → ignored; no extra load.
- Reset at SHIFT bit 7 → serialEn drops the next cycle, no done pulse. A following load completes normally with readbackData=0.
